// File: rtl/inst_decode.sv
// RV64I decode stage: registers fetch output, decodes fields/immediates, inserts load-use bubbles.
// Optional macro RV64M_EN adds M-extension decode and the is_muldiv output.
module inst_decode #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall_in,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_of_inst,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      funct3,
  output logic [4:0]      alu_op,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            reg_we,
  output logic            illegal,
`ifdef RV64M_EN
  output logic            is_muldiv,
`endif
  output logic            stall_out
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_REG32  = 7'b0111011;

  typedef enum logic {S_RUN, S_BUBBLE} state_t;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [4:0]      alu_op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            is_auipc;
    logic            reg_we;
    logic            illegal;
`ifdef RV64M_EN
    logic            is_muldiv;
`endif
  } dec_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{(XLEN-12){ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
    return {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] ins);
    return {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       word;
    logic       alt;
    d        = '0;
    f3       = ins[14:12];
    f7       = ins[31:25];
    legal    = 1'b0;
    word     = 1'b0;
    alt      = 1'b0;
    d.funct3 = f3;
    case (ins[6:0])
      OPC_LOAD: begin
        legal     = (f3 != 3'b111);
        d.rd      = ins[11:7];
        d.rs1     = ins[19:15];
        d.imm     = imm_i(ins);
        d.is_load = 1'b1;
        d.reg_we  = 1'b1;
      end
      OPC_STORE: begin
        legal      = ~f3[2];
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.imm      = imm_s(ins);
        d.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        legal       = (f3[2:1] != 2'b01);
        d.rs1       = ins[19:15];
        d.rs2       = ins[24:20];
        d.imm       = imm_b(ins);
        d.alu_op    = 5'b01000;
        d.is_branch = 1'b1;
      end
      OPC_JAL: begin
        legal    = 1'b1;
        d.rd     = ins[11:7];
        d.imm    = imm_j(ins);
        d.is_jal = 1'b1;
        d.reg_we = 1'b1;
      end
      OPC_JALR: begin
        legal     = (f3 == 3'b000);
        d.rd      = ins[11:7];
        d.rs1     = ins[19:15];
        d.imm     = imm_i(ins);
        d.is_jalr = 1'b1;
        d.reg_we  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal      = 1'b1;
        d.rd       = ins[11:7];
        d.imm      = imm_u(ins);
        d.is_lui   = (ins[6:0] == OPC_LUI);
        d.is_auipc = (ins[6:0] == OPC_AUIPC);
        d.reg_we   = 1'b1;
      end
      OPC_IMM: begin
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.imm    = imm_i(ins);
        d.reg_we = 1'b1;
        // RV64 shifts carry a 6-bit shamt, so only inst[31:26] is the function field
        case (f3)
          3'b001:  legal = (ins[31:26] == 6'b000000);
          3'b101: begin
            legal = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
            alt   = ins[30];
          end
          default: legal = 1'b1;
        endcase
        d.alu_op = {1'b0, alt, f3};
      end
      OPC_IMM32: begin
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.imm    = imm_i(ins);
        d.reg_we = 1'b1;
        case (f3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101: begin
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            alt   = ins[30];
          end
          default: legal = 1'b0;
        endcase
        d.alu_op = {1'b1, alt, f3};
      end
      OPC_REG, OPC_REG32: begin
        word     = (ins[6:0] == OPC_REG32);
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.reg_we = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = ~word || (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          alt   = 1'b1;
`ifdef RV64M_EN
        end else if (f7 == 7'b0000001) begin
          legal       = ~word || (f3 == 3'b000) || f3[2];
          d.is_muldiv = 1'b1;
`endif
        end
        d.alu_op = {word, alt, f3};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.is_branch = 1'b0;
      d.is_jal    = 1'b0;
      d.is_jalr   = 1'b0;
      d.is_lui    = 1'b0;
      d.is_auipc  = 1'b0;
      d.reg_we    = 1'b0;
      d.alu_op    = '0;
      d.illegal   = 1'b1;
`ifdef RV64M_EN
      d.is_muldiv = 1'b0;
`endif
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
    return d;
  endfunction

  function automatic dec_t bubble();
    dec_t d;
    d           = decode(NOP_INST);
    d.is_load   = 1'b0;
    d.is_store  = 1'b0;
    d.is_branch = 1'b0;
    d.is_jal    = 1'b0;
    d.is_jalr   = 1'b0;
    d.is_lui    = 1'b0;
    d.is_auipc  = 1'b0;
    d.reg_we    = 1'b0;
`ifdef RV64M_EN
    d.is_muldiv = 1'b0;
`endif
    return d;
  endfunction

  state_t          state_q, state_d;
  dec_t            out_q, out_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  dec_t            dec_in;
  logic            uses_rs2;
  logic            hazard;

  assign dec_in   = decode(inst);
  assign uses_rs2 = (inst[6:0] == OPC_REG) || (inst[6:0] == OPC_REG32) ||
                    (inst[6:0] == OPC_STORE) || (inst[6:0] == OPC_BRANCH);
  // Load in decode whose rd feeds the instruction now waiting in fetch
  assign hazard   = id_valid_q && out_q.is_load && (out_q.rd != 5'd0) &&
                    ((out_q.rd == dec_in.rs1) || (uses_rs2 && (out_q.rd == dec_in.rs2)));

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    stall_out  = 1'b0;
    if (flush) begin
      state_d    = S_RUN;
      out_d      = bubble();
      id_valid_d = 1'b0;
      id_pc_d    = '0;
    end else if (!stall_in) begin
      case (state_q)
        S_RUN: begin
          if (hazard) begin
            stall_out  = 1'b1;
            state_d    = S_BUBBLE;
            out_d      = bubble();
            id_valid_d = 1'b0;
            id_pc_d    = '0;
          end else begin
            out_d      = dec_in;
            id_valid_d = 1'b1;
            id_pc_d    = pc_of_inst;
          end
        end
        S_BUBBLE: begin
          state_d    = S_RUN;
          out_d      = dec_in;
          id_valid_d = 1'b1;
          id_pc_d    = pc_of_inst;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      out_q      <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign funct3    = out_q.funct3;
  assign alu_op    = out_q.alu_op;
  assign is_load   = out_q.is_load;
  assign is_store  = out_q.is_store;
  assign is_branch = out_q.is_branch;
  assign is_jal    = out_q.is_jal;
  assign is_jalr   = out_q.is_jalr;
  assign is_lui    = out_q.is_lui;
  assign is_auipc  = out_q.is_auipc;
  assign reg_we    = out_q.reg_we;
  assign illegal   = out_q.illegal;
`ifdef RV64M_EN
  assign is_muldiv = out_q.is_muldiv;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: stimulus queues expected responses, a monitor pops and compares.
module tb_inst_decode;
  localparam int XLEN = 64;

  logic            CLK = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            stall_in = 1'b0;
  logic [31:0]     inst = 32'h0;
  logic [XLEN-1:0] pc_of_inst = '0;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      funct3;
  logic [4:0]      alu_op;
  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic            reg_we, illegal, stall_out;
`ifdef RV64M_EN
  logic            is_muldiv;
`endif

  inst_decode #(.XLEN(XLEN), .NOP_INST(32'h00000013)) dut (
    .CLK(CLK), .reset(reset), .flush(flush), .stall_in(stall_in),
    .inst(inst), .pc_of_inst(pc_of_inst),
    .id_valid(id_valid), .id_pc(id_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc),
    .reg_we(reg_we), .illegal(illegal),
`ifdef RV64M_EN
    .is_muldiv(is_muldiv),
`endif
    .stall_out(stall_out)
  );

  always #5 CLK = ~CLK;

  // flag order: {load, store, branch, jal, jalr, lui, auipc, reg_we, illegal}
  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_WE   = 9'b000000010;
  localparam logic [8:0] F_LD   = 9'b100000010;
  localparam logic [8:0] F_LD0  = 9'b100000000;
  localparam logic [8:0] F_ST   = 9'b010000000;
  localparam logic [8:0] F_BR   = 9'b001000000;
  localparam logic [8:0] F_JAL  = 9'b000100010;
  localparam logic [8:0] F_LUI  = 9'b000001010;
  localparam logic [8:0] F_ILL  = 9'b000000001;

  typedef struct {
    logic        stall;
    logic        full;
    logic        vld;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd, alu;
    logic [2:0]  f3;
    logic [8:0]  flg;
    logic        md;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ev(input logic vld, input logic [63:0] pc, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] rdd, input logic [2:0] f3,
                              input logic [63:0] im, input logic [4:0] alu, input logic [8:0] flg,
                              input logic md);
    exp_t e;
    e.stall = 1'b0; e.full = 1'b1; e.vld = vld; e.pc = pc;
    e.rs1 = r1; e.rs2 = r2; e.rd = rdd; e.f3 = f3; e.imm = im;
    e.alu = alu; e.flg = flg; e.md = md;
    return e;
  endfunction

  function automatic exp_t ill(input logic [63:0] pc);
    exp_t e;
    e = ev(1'b1, pc, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 5'd0, F_ILL, 1'b0);
    e.full = 1'b0;
    return e;
  endfunction

  task automatic step(input logic [31:0] i, input logic [63:0] pc, input logic fl,
                      input logic st, input logic exp_stall, input exp_t e);
    exp_t x;
    @(negedge CLK);
    inst = i; pc_of_inst = pc; flush = fl; stall_in = st;
    x = e;
    x.stall = exp_stall;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge CLK);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Monitor: stall_out is combinational so it is checked before the edge, registers after it
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        chk("stall_out", 64'(stall_out), 64'(e.stall));
        @(posedge CLK);
        #1;
        chk("id_valid", 64'(id_valid), 64'(e.vld));
        chk("flags", 64'({is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc,
                          reg_we, illegal}), 64'(e.flg));
        if (e.vld) chk("id_pc", id_pc, e.pc);
        if (e.full) begin
          chk("regs", 64'({rs1, rs2, rd, funct3}), 64'({e.rs1, e.rs2, e.rd, e.f3}));
          chk("imm", imm, e.imm);
          chk("alu_op", 64'(alu_op), 64'(e.alu));
        end
`ifdef RV64M_EN
        chk("is_muldiv", 64'(is_muldiv), 64'(e.md));
`endif
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t bub, ld11c, mul_e;
    bub   = ev(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 5'd0, F_NONE, 1'b0);
    ld11c = ev(1'b1, 64'h11C, 5'd1, 5'd0, 5'd2, 3'd3, 64'd0, 5'd0, F_LD, 1'b0);
`ifdef RV64M_EN
    mul_e = ev(1'b1, 64'h144, 5'd6, 5'd7, 5'd5, 3'd0, 64'd0, 5'd0, F_WE, 1'b1);
`else
    mul_e = ill(64'h144);
`endif

    repeat (2) @(posedge CLK);
    #2;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_stall_out", 64'(stall_out), 64'd0);
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_imm", imm, 64'd0);
    @(negedge CLK);
    reset = 1'b1;

    step(32'h00500093, 64'h100, 0, 0, 0, ev(1, 64'h100, 0, 0, 1, 0, 64'd5, 0, F_WE, 0));
    step(32'h0000B103, 64'h104, 0, 0, 0, ev(1, 64'h104, 1, 0, 2, 3, 64'd0, 0, F_LD, 0));
    step(32'h002101B3, 64'h108, 0, 0, 1, bub);
    step(32'h002101B3, 64'h108, 0, 0, 0, ev(1, 64'h108, 2, 2, 3, 0, 64'd0, 0, F_WE, 0));
    step(32'h0000B103, 64'h10C, 0, 0, 0, ev(1, 64'h10C, 1, 0, 2, 3, 64'd0, 0, F_LD, 0));
    step(32'h00100113, 64'h110, 0, 0, 0, ev(1, 64'h110, 0, 0, 2, 0, 64'd1, 0, F_WE, 0));
    step(32'h0000B103, 64'h114, 0, 0, 0, ev(1, 64'h114, 1, 0, 2, 3, 64'd0, 0, F_LD, 0));
    step(32'h002101B3, 64'h118, 1, 0, 0, bub);
    step(32'h002101B3, 64'h118, 0, 0, 0, ev(1, 64'h118, 2, 2, 3, 0, 64'd0, 0, F_WE, 0));
    step(32'h0000B103, 64'h11C, 0, 0, 0, ld11c);
    step(32'h002101B3, 64'h120, 0, 1, 0, ld11c);
    step(32'h00500093, 64'h124, 0, 1, 0, ld11c);
    step(32'h0000B283, 64'h128, 0, 1, 0, ld11c);
    step(32'h407302B3, 64'h120, 0, 0, 0, ev(1, 64'h120, 6, 7, 5, 0, 64'd0, 5'b01000, F_WE, 0));
    step(32'h43F0D213, 64'h124, 0, 0, 0, ev(1, 64'h124, 1, 0, 4, 5, 64'h43F, 5'b01101, F_WE, 0));
    step(32'h43F0D21B, 64'h128, 0, 0, 0, ill(64'h128));
    step(32'h41F0D21B, 64'h12C, 0, 0, 0, ev(1, 64'h12C, 1, 0, 4, 5, 64'h41F, 5'b11101, F_WE, 0));
    step(32'h0000B283, 64'h130, 0, 0, 0, ev(1, 64'h130, 1, 0, 5, 3, 64'd0, 0, F_LD, 0));
    step(32'hFE532E23, 64'h134, 0, 0, 1, bub);
    step(32'hFE532E23, 64'h134, 0, 0, 0,
         ev(1, 64'h134, 6, 5, 0, 2, 64'hFFFF_FFFF_FFFF_FFFC, 0, F_ST, 0));
    step(32'hFE208CE3, 64'h138, 0, 0, 0,
         ev(1, 64'h138, 1, 2, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 5'b01000, F_BR, 0));
    step(32'h001000EF, 64'h13C, 0, 0, 0, ev(1, 64'h13C, 0, 0, 1, 0, 64'h800, 0, F_JAL, 0));
    step(32'h800003B7, 64'h140, 0, 0, 0,
         ev(1, 64'h140, 0, 0, 7, 0, 64'hFFFF_FFFF_8000_0000, 0, F_LUI, 0));
    step(32'h027302B3, 64'h144, 0, 0, 0, mul_e);
    step(32'hFFFFFFFF, 64'h148, 0, 0, 0, ill(64'h148));
    step(32'h00004501, 64'h14C, 0, 0, 0, ill(64'h14C));
    step(32'h00100013, 64'h150, 0, 0, 0, ev(1, 64'h150, 0, 0, 0, 0, 64'd1, 0, F_NONE, 0));
    step(32'h00003003, 64'h154, 0, 0, 0, ev(1, 64'h154, 0, 0, 0, 3, 64'd0, 0, F_LD0, 0));
    step(32'h00500093, 64'h158, 0, 0, 0, ev(1, 64'h158, 0, 0, 1, 0, 64'd5, 0, F_WE, 0));
    drain();

    @(negedge CLK);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_id_valid", 64'(id_valid), 64'd0);
    chk("async_rst_rd", 64'(rd), 64'd0);
    chk("async_rst_imm", imm, 64'd0);
    @(negedge CLK);
    reset = 1'b1;
    step(32'h002101B3, 64'h200, 0, 0, 0, ev(1, 64'h200, 2, 2, 3, 0, 64'd0, 0, F_WE, 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
